sim_test_reporter: RTL

//  Memory-mapped test-status peripheral that firmware writes during simulation; drives the

---
 rtl/sim_test_reporter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sim_test_reporter.sv
// sim_test_reporter: write-only test-status peripheral feeding report/done to the sim finisher.
// Byte-strobed report word, magic-word termination, drain delay before done, kickable watchdog.
module sim_test_reporter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned DRAIN_CYCLES   = 8,
  parameter logic [31:0] PASS_MAGIC     = 32'hC0DE_600D,
  parameter logic [31:0] FAIL_MAGIC     = 32'hDEAD_C0DE,
  parameter logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0D06
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [31:0] report,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]  A_REPORT   = 2'd0;
  localparam logic [1:0]  A_CTRL     = 2'd1;
  localparam logic [1:0]  A_KICK     = 2'd2;
  localparam logic [1:0]  A_WDOG_EN  = 2'd3;
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES);
  localparam logic [31:0] WDOG_LAST  = TIMEOUT_CYCLES - 32'd1;

  state_t      state_r, state_nxt_s;
  logic [31:0] report_r, report_nxt_s;
  logic        done_r, done_nxt_s;
  logic        pass_r, pass_nxt_s;
  logic        timeout_r, timeout_nxt_s;
  logic        wr_ready_r, wr_ready_nxt_s;
  logic        wdog_en_r, wdog_en_nxt_s;
  logic [31:0] wdog_cnt_r, wdog_cnt_nxt_s;
  logic [31:0] drain_cnt_r, drain_cnt_nxt_s;

  logic        accept_s;
  logic        full_s;
  logic        wr_report_s;
  logic        wr_kick_s;
  logic        wr_wen_s;
  logic        is_pass_s;
  logic        is_fail_s;
  logic        expire_s;
  logic        addr_unused_s;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign accept_s      = wr_valid & wr_ready_r;
  assign full_s        = (wr_strb == 4'hF);
  assign wr_report_s   = accept_s & (wr_addr[3:2] == A_REPORT);
  assign wr_kick_s     = accept_s & full_s & (wr_addr[3:2] == A_KICK);
  assign wr_wen_s      = accept_s & full_s & (wr_addr[3:2] == A_WDOG_EN);
  assign is_pass_s     = accept_s & full_s & (wr_addr[3:2] == A_CTRL) & (wr_data == PASS_MAGIC);
  assign is_fail_s     = accept_s & full_s & (wr_addr[3:2] == A_CTRL) & (wr_data == FAIL_MAGIC);
  assign expire_s      = wdog_en_r & (wdog_cnt_r == WDOG_LAST);
  assign addr_unused_s = ^wr_addr[1:0];

  // Next-state and next-output computation for the RUN/DRAIN/DONE sequencer
  always_comb begin
    state_nxt_s     = state_r;
    report_nxt_s    = report_r;
    done_nxt_s      = done_r;
    pass_nxt_s      = pass_r;
    timeout_nxt_s   = timeout_r;
    wdog_en_nxt_s   = wdog_en_r;
    wdog_cnt_nxt_s  = wdog_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    // One-cycle bubble after every accept, independent of state, so the bus never hangs
    wr_ready_nxt_s  = ~accept_s;

    case (state_r)
      ST_RUN: begin
        if (wr_report_s) begin
          report_nxt_s = strb_merge(report_r, wr_data, wr_strb);
        end else begin
          report_nxt_s = report_r;
        end

        if (wr_wen_s) begin
          wdog_en_nxt_s  = wr_data[0];
          wdog_cnt_nxt_s = 32'd0;
        end else if (wr_kick_s) begin
          wdog_cnt_nxt_s = 32'd0;
        end else if (wdog_en_r) begin
          wdog_cnt_nxt_s = wdog_cnt_r + 32'd1;
        end else begin
          wdog_cnt_nxt_s = wdog_cnt_r;
        end

        // Magic words and kicks take priority over a coincident expiry
        if (is_pass_s) begin
          pass_nxt_s      = 1'b1;
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = 32'd0;
          wdog_cnt_nxt_s  = 32'd0;
        end else if (is_fail_s) begin
          pass_nxt_s      = 1'b0;
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = 32'd0;
          wdog_cnt_nxt_s  = 32'd0;
        end else if (expire_s && !wr_wen_s && !wr_kick_s) begin
          report_nxt_s    = TIMEOUT_CODE;
          timeout_nxt_s   = 1'b1;
          pass_nxt_s      = 1'b0;
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = 32'd0;
          wdog_cnt_nxt_s  = 32'd0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (wr_report_s) begin
          report_nxt_s = strb_merge(report_r, wr_data, wr_strb);
        end else begin
          report_nxt_s = report_r;
        end

        if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_DONE;
          done_nxt_s  = 1'b1;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r + 32'd1;
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_DONE;
        done_nxt_s  = 1'b1;
      end

      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      report_r    <= 32'd0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      wr_ready_r  <= 1'b1;
      wdog_en_r   <= 1'b0;
      wdog_cnt_r  <= 32'd0;
      drain_cnt_r <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      report_r    <= report_nxt_s;
      done_r      <= done_nxt_s;
      pass_r      <= pass_nxt_s;
      timeout_r   <= timeout_nxt_s;
      wr_ready_r  <= wr_ready_nxt_s;
      wdog_en_r   <= wdog_en_nxt_s;
      wdog_cnt_r  <= wdog_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  assign wr_ready = wr_ready_r;
  assign report   = report_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign timeout  = timeout_r;

endmodule
